router_pkt_tx: RTL and testbench

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

---
 rtl/router_pkt_tx.sv | 158 +++++++++++++++
 tb/tb_router_pkt_tx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers up to 63 payload bytes, then frames them as
// header, source tag, payload and XOR parity toward the router.
module router_pkt_tx #(
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk1,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       tx_start,
  input  logic [1:0] tx_dest,
  input  logic [7:0] tx_src,
  input  logic       stop_packet_send,
  output logic [7:0] packet_in,
  output logic       packet_valid_i,
  output logic [5:0] buf_count,
  output logic       buf_full,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_SRC  = 3'd2;
  localparam logic [2:0] S_PAY  = 3'd3;
  localparam logic [2:0] S_PAR  = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  logic [7:0] r_mem [0:63];
  logic [2:0] r_state;
  logic [5:0] r_buf_count;
  logic [5:0] r_rd_ptr;
  logic [5:0] r_len;
  logic [7:0] r_src;
  logic [7:0] r_par;
  logic [7:0] r_pkt;
  logic       r_valid;
  logic       r_done;
  logic       r_err;
  logic [3:0] r_gap;

  logic       w_wr_ok;
  logic       w_start_ok;
  logic       w_xfer;
  logic [5:0] w_len;
  logic [7:0] w_hdr;
  logic [7:0] w_rd_byte;

  // A write in the same cycle as tx_start is counted into the packet length.
  assign w_wr_ok    = wr_en && (r_state == S_IDLE) && (r_buf_count != 6'd63);
  assign w_len      = r_buf_count + {5'd0, w_wr_ok};
  assign w_start_ok = (tx_dest != 2'd3) && (w_len != 6'd0);
  assign w_hdr      = {w_len, tx_dest};
  assign w_xfer     = r_valid && !stop_packet_send;
  assign w_rd_byte  = r_mem[r_rd_ptr];

  always_ff @(posedge clk1) begin
    if (!reset && w_wr_ok) begin
      r_mem[r_buf_count] <= wr_data;
    end
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_buf_count <= 6'd0;
      r_rd_ptr    <= 6'd0;
      r_len       <= 6'd0;
      r_src       <= 8'h00;
      r_par       <= 8'h00;
      r_pkt       <= 8'h00;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_gap       <= 4'd0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_wr_ok) begin
        r_buf_count <= r_buf_count + 6'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (tx_start) begin
            if (w_start_ok) begin
              r_len   <= w_len;
              r_src   <= tx_src;
              r_pkt   <= w_hdr;
              r_par   <= w_hdr ^ tx_src;
              r_valid <= 1'b1;
              r_state <= S_HDR;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_HDR: begin
          if (w_xfer) begin
            r_pkt   <= r_src;
            r_state <= S_SRC;
          end
        end
        S_SRC: begin
          if (w_xfer) begin
            r_pkt    <= w_rd_byte;
            r_par    <= r_par ^ w_rd_byte;
            r_rd_ptr <= r_rd_ptr + 6'd1;
            r_state  <= S_PAY;
          end
        end
        S_PAY: begin
          // r_rd_ptr counts payload bytes already presented on packet_in.
          if (w_xfer) begin
            if (r_rd_ptr == r_len) begin
              r_pkt   <= r_par;
              r_state <= S_PAR;
            end else begin
              r_pkt    <= w_rd_byte;
              r_par    <= r_par ^ w_rd_byte;
              r_rd_ptr <= r_rd_ptr + 6'd1;
            end
          end
        end
        S_PAR: begin
          if (w_xfer) begin
            r_pkt       <= 8'h00;
            r_valid     <= 1'b0;
            r_done      <= 1'b1;
            r_buf_count <= 6'd0;
            r_rd_ptr    <= 6'd0;
            r_gap       <= GAP_LOAD;
            r_state     <= S_GAP;
          end
        end
        S_GAP: begin
          if (r_gap == 4'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign packet_in      = r_pkt;
  assign packet_valid_i = r_valid;
  assign buf_count      = r_buf_count;
  assign buf_full       = (r_buf_count == 6'd63);
  assign tx_busy        = (r_state != S_IDLE);
  assign tx_done        = r_done;
  assign tx_err         = r_err;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: framing, stalls, rejects, full buffer,
// mid-packet reset and back-to-back packets.
module tb_router_pkt_tx;

  logic       clk1;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx_start;
  logic [1:0] tx_dest;
  logic [7:0] tx_src;
  logic       stop_packet_send;
  logic [7:0] packet_in;
  logic       packet_valid_i;
  logic [5:0] buf_count;
  logic       buf_full;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;

  router_pkt_tx #(.GAP_CYCLES(1)) dut (
    .clk1(clk1), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .tx_start(tx_start), .tx_dest(tx_dest), .tx_src(tx_src),
    .stop_packet_send(stop_packet_send), .packet_in(packet_in),
    .packet_valid_i(packet_valid_i), .buf_count(buf_count),
    .buf_full(buf_full), .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  int         n_vec = 0;
  int         n_miss = 0;
  int         valid_cycles;
  logic [7:0] rx_q[$];
  logic [7:0] pay_q[$];
  logic [7:0] exp_q[$];

  // Inputs change on the falling edge; a byte counts as transferred when the
  // coming rising edge sees valid high and stop low.
  task automatic step();
    if (packet_valid_i && !stop_packet_send && !reset) rx_q.push_back(packet_in);
    if (packet_valid_i) valid_cycles++;
    @(negedge clk1);
  endtask

  task automatic apply_reset();
    reset = 1'b1; wr_en = 1'b0; tx_start = 1'b0; stop_packet_send = 1'b0;
    step(); step();
    reset = 1'b0;
    rx_q.delete();
    valid_cycles = 0;
  endtask

  task automatic write_pay();
    foreach (pay_q[i]) begin
      wr_en = 1'b1; wr_data = pay_q[i];
      step();
    end
    wr_en = 1'b0;
  endtask

  task automatic send(input logic [1:0] d, input logic [7:0] s);
    rx_q.delete();
    valid_cycles = 0;
    tx_start = 1'b1; tx_dest = d; tx_src = s;
    step();
    tx_start = 1'b0;
  endtask

  task automatic build_exp(input logic [1:0] d, input logic [7:0] s);
    logic [7:0] hdr;
    logic [7:0] par;
    exp_q.delete();
    hdr = {6'(pay_q.size()), d};
    par = hdr ^ s;
    exp_q.push_back(hdr);
    exp_q.push_back(s);
    foreach (pay_q[i]) begin
      exp_q.push_back(pay_q[i]);
      par = par ^ pay_q[i];
    end
    exp_q.push_back(par);
  endtask

  task automatic wait_done(input int budget, input int stall_idx, input int stall_len,
                           output bit done_seen, output int hold, output int bubble);
    int left;
    left = stall_len; done_seen = 1'b0; hold = 0; bubble = 0;
    for (int c = 0; c < budget; c++) begin
      if (tx_done) begin
        done_seen = 1'b1;
        break;
      end
      if (!packet_valid_i) bubble++;
      stop_packet_send = 1'b0;
      if (packet_valid_i && rx_q.size() == stall_idx) begin
        hold++;
        if (left > 0) begin
          stop_packet_send = 1'b1;
          left--;
        end
      end
      step();
    end
    stop_packet_send = 1'b0;
  endtask

  task automatic test_reset();
    n_vec++; if (packet_in !== 8'h00) begin n_miss++; $display("FAIL reset_data got %h want 00", packet_in); end
    n_vec++; if (packet_valid_i !== 1'b0) begin n_miss++; $display("FAIL reset_valid got %b want 0", packet_valid_i); end
    n_vec++; if (buf_count !== 6'd0) begin n_miss++; $display("FAIL reset_count got %0d want 0", buf_count); end
    n_vec++; if (buf_full !== 1'b0) begin n_miss++; $display("FAIL reset_full got %b want 0", buf_full); end
    n_vec++; if (tx_busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy got %b want 0", tx_busy); end
    n_vec++; if (tx_done !== 1'b0) begin n_miss++; $display("FAIL reset_done got %b want 0", tx_done); end
    n_vec++; if (tx_err !== 1'b0) begin n_miss++; $display("FAIL reset_err got %b want 0", tx_err); end
    $display("test_reset: outputs idle after reset");
  endtask

  // Hand-computed frame: hdr {3,1}=0D, src 9F, payload, parity 0D^9F^02^F0^0F=6F.
  task automatic test_basic(input int stall_len, input string tag);
    logic [7:0] want [6];
    bit done_seen;
    int hold, bubble;
    want = '{8'h0D, 8'h9F, 8'h02, 8'hF0, 8'h0F, 8'h6F};
    apply_reset();
    pay_q = '{8'h02, 8'hF0, 8'h0F};
    write_pay();
    n_vec++; if (buf_count !== 6'd3) begin n_miss++; $display("FAIL %s_count got %0d want 3", tag, buf_count); end
    send(2'd1, 8'h9F);
    n_vec++; if (packet_valid_i !== 1'b1 || packet_in !== 8'h0D) begin n_miss++; $display("FAIL %s_hdr_latency got %b/%h want 1/0d", tag, packet_valid_i, packet_in); end
    n_vec++; if (tx_busy !== 1'b1) begin n_miss++; $display("FAIL %s_busy got %b want 1", tag, tx_busy); end
    wait_done(40, 3, stall_len, done_seen, hold, bubble);
    n_vec++; if (!done_seen) begin n_miss++; $display("FAIL %s_timeout got no tx_done want tx_done", tag); end
    n_vec++; if (rx_q.size() !== 6) begin n_miss++; $display("FAIL %s_len got %0d want 6", tag, rx_q.size()); end
    for (int i = 0; i < 6; i++) begin
      logic [7:0] got;
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      n_vec++; if (got !== want[i]) begin n_miss++; $display("FAIL %s_byte%0d got %h want %h", tag, i, got, want[i]); end
    end
    n_vec++; if (bubble !== 0) begin n_miss++; $display("FAIL %s_bubble got %0d want 0", tag, bubble); end
    n_vec++; if (valid_cycles !== 6 + stall_len) begin n_miss++; $display("FAIL %s_valid_cycles got %0d want %0d", tag, valid_cycles, 6 + stall_len); end
    n_vec++; if (hold !== 1 + stall_len) begin n_miss++; $display("FAIL %s_hold got %0d want %0d", tag, hold, 1 + stall_len); end
    n_vec++; if (packet_valid_i !== 1'b0 || buf_count !== 6'd0) begin n_miss++; $display("FAIL %s_end got valid %b count %0d want 0 0", tag, packet_valid_i, buf_count); end
    step();
    n_vec++; if (tx_done !== 1'b0) begin n_miss++; $display("FAIL %s_done_pulse got %b want 0", tag, tx_done); end
    $display("%s: packet of %0d bytes, stall %0d", tag, rx_q.size(), stall_len);
  endtask

  task automatic test_errors();
    bit done_seen;
    int hold, bubble;
    apply_reset();
    pay_q = '{8'h11, 8'h22};
    write_pay();
    send(2'd3, 8'h05);
    n_vec++; if (tx_err !== 1'b1) begin n_miss++; $display("FAIL err_dest got %b want 1", tx_err); end
    n_vec++; if (packet_valid_i !== 1'b0 || tx_busy !== 1'b0) begin n_miss++; $display("FAIL err_dest_idle got valid %b busy %b want 0 0", packet_valid_i, tx_busy); end
    step();
    n_vec++; if (tx_err !== 1'b0) begin n_miss++; $display("FAIL err_pulse got %b want 0", tx_err); end
    n_vec++; if (buf_count !== 6'd2) begin n_miss++; $display("FAIL err_retain got %0d want 2", buf_count); end
    send(2'd2, 8'h01);
    n_vec++; if (packet_in !== 8'h0A) begin n_miss++; $display("FAIL err_resend_hdr got %h want 0a", packet_in); end
    wait_done(40, -1, 0, done_seen, hold, bubble);
    build_exp(2'd2, 8'h01);
    n_vec++; if (!done_seen || rx_q != exp_q) begin n_miss++; $display("FAIL err_resend_pkt got %0d bytes want %0d", rx_q.size(), exp_q.size()); end
    step(); step();
    send(2'd0, 8'h00);
    n_vec++; if (tx_err !== 1'b1 || packet_valid_i !== 1'b0) begin n_miss++; $display("FAIL err_empty got err %b valid %b want 1 0", tx_err, packet_valid_i); end
    $display("test_errors: bad dest and empty buffer rejected");
  endtask

  task automatic test_full();
    bit done_seen;
    int hold, bubble;
    apply_reset();
    pay_q.delete();
    for (int i = 0; i < 64; i++) pay_q.push_back(8'(i * 7 + 3));
    write_pay();
    void'(pay_q.pop_back());
    n_vec++; if (buf_count !== 6'd63 || buf_full !== 1'b1) begin n_miss++; $display("FAIL full_count got %0d/%b want 63/1", buf_count, buf_full); end
    send(2'd0, 8'h80);
    n_vec++; if (packet_in !== 8'hFC) begin n_miss++; $display("FAIL full_hdr got %h want fc", packet_in); end
    wait_done(200, -1, 0, done_seen, hold, bubble);
    build_exp(2'd0, 8'h80);
    n_vec++; if (!done_seen || rx_q.size() !== 66) begin n_miss++; $display("FAIL full_len got %0d want 66", rx_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [7:0] got;
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      n_vec++; if (got !== exp_q[i]) begin n_miss++; $display("FAIL full_byte%0d got %h want %h", i, got, exp_q[i]); end
    end
    $display("test_full: 63-byte packet, %0d bytes sent", rx_q.size());
  endtask

  task automatic test_reset_mid();
    bit done_seen;
    int hold, bubble;
    apply_reset();
    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    write_pay();
    send(2'd2, 8'h33);
    for (int c = 0; c < 20 && rx_q.size() < 4; c++) step();
    n_vec++; if (rx_q.size() !== 4 || packet_in !== 8'h03) begin n_miss++; $display("FAIL mid_reach got %0d/%h want 4/03", rx_q.size(), packet_in); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_vec++; if (packet_valid_i !== 1'b0 || buf_count !== 6'd0 || tx_busy !== 1'b0) begin n_miss++; $display("FAIL mid_abort got valid %b count %0d busy %b want 0 0 0", packet_valid_i, buf_count, tx_busy); end
    pay_q = '{8'hA5};
    write_pay();
    send(2'd1, 8'h44);
    wait_done(40, -1, 0, done_seen, hold, bubble);
    build_exp(2'd1, 8'h44);
    n_vec++; if (!done_seen || rx_q != exp_q) begin n_miss++; $display("FAIL mid_resend got %0d bytes want %0d", rx_q.size(), exp_q.size()); end
    $display("test_reset_mid: abort then clean resend");
  endtask

  task automatic test_back_to_back();
    bit done_seen;
    int hold, bubble;
    apply_reset();
    pay_q = '{8'hA1, 8'hA2};
    write_pay();
    send(2'd1, 8'h10);
    wr_en = 1'b1; wr_data = 8'hEE;
    step();
    wr_en = 1'b0;
    n_vec++; if (buf_count !== 6'd2) begin n_miss++; $display("FAIL b2b_busy_write got %0d want 2", buf_count); end
    wait_done(40, -1, 0, done_seen, hold, bubble);
    build_exp(2'd1, 8'h10);
    n_vec++; if (!done_seen || rx_q != exp_q) begin n_miss++; $display("FAIL b2b_first got %0d bytes want %0d", rx_q.size(), exp_q.size()); end
    n_vec++; if (packet_valid_i !== 1'b0 || tx_busy !== 1'b1) begin n_miss++; $display("FAIL b2b_gap got valid %b busy %b want 0 1", packet_valid_i, tx_busy); end
    wr_en = 1'b1; wr_data = 8'h77;
    step();
    wr_en = 1'b0;
    n_vec++; if (packet_valid_i !== 1'b0 || tx_busy !== 1'b0 || buf_count !== 6'd0) begin n_miss++; $display("FAIL b2b_idle got valid %b busy %b count %0d want 0 0 0", packet_valid_i, tx_busy, buf_count); end
    pay_q = '{8'h3C};
    wr_en = 1'b1; wr_data = 8'h3C;
    send(2'd2, 8'h20);
    wr_en = 1'b0;
    n_vec++; if (packet_valid_i !== 1'b1 || packet_in !== 8'h06) begin n_miss++; $display("FAIL b2b_second_hdr got %b/%h want 1/06", packet_valid_i, packet_in); end
    wait_done(40, -1, 0, done_seen, hold, bubble);
    build_exp(2'd2, 8'h20);
    n_vec++; if (!done_seen || rx_q != exp_q) begin n_miss++; $display("FAIL b2b_second got %0d bytes want %0d", rx_q.size(), exp_q.size()); end
    $display("test_back_to_back: two packets, 2 idle cycles between");
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_start = 1'b0;
    tx_dest = 2'd0; tx_src = 8'h00; stop_packet_send = 1'b0;
    valid_cycles = 0;
    @(negedge clk1);
    @(negedge clk1);
    test_reset();
    reset = 1'b0;
    test_basic(0, "test_basic");
    test_basic(3, "test_stall");
    test_errors();
    test_full();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
